// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch slice: FSM state encoding,
// reset/NOP defaults, PC increment and the word-alignment mask applied to
// every redirect target.
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry holding register for a fetched {instr, pc, pc4} triple that
// arrived while decode was stalled.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_clr             flush (redirect); wins over load/pop
//   i_load            capture i_instr/i_pc/i_pc4, entry becomes full
//   i_pop             entry consumed by the output stage, becomes empty
//   o_full            entry holds live data
//   o_instr/o_pc/o_pc4 stored triple
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_pc4,
  input  logic              i_pop,
  output logic              o_full,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc4
);

  logic              r_full;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage: owns the PC, issues word fetches to instruction
// memory, forms branch/jump redirect targets and hands instructions to
// decode through a one-entry skid buffer.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   br_taken, br_pc4, br_off   taken branch: target = br_pc4 + br_off (byte offset)
//   jmp, jmp_target            absolute jump, wins over br_taken
//   imem_req/addr/ack/rdata    instruction-memory request channel
//   if_valid/ready/instr/pc/pc4 decode channel
//   misalign                   one-cycle pulse after an unaligned redirect target
//   dbg_state                  current FSM state (0 = IDLE, 1 = REQ)
//
// Handshakes: imem_req/imem_addr are held stable until the cycle imem_ack is
// high (ack may arrive in the request cycle). if_valid with if_* is held
// stable until the cycle if_ready is high; the transfer happens on the rising
// edge where both are high. A redirect drops whatever is pending.
module pc_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(fetch_pkg::RESET_PC),
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(fetch_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc4,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output logic              misalign,
  output logic              dbg_state
);
  import fetch_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_stale_addr;
  logic              r_drop;
  logic              r_misalign;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_pc4;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_raw_target;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_req_active;
  logic              w_ack_live;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_load_if;
  logic              w_load_skid;
  logic              w_pop_skid;
  logic              w_skid_full;
  logic [DATA_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0] w_skid_pc;
  logic [ADDR_W-1:0] w_skid_pc4;

  assign w_redirect   = jmp | br_taken;
  assign w_raw_target = jmp ? jmp_target : (br_pc4 + br_off);
  assign w_target     = w_raw_target & ADDR_W'(ALIGN_MASK);
  assign w_pc_plus4   = r_pc + ADDR_W'(PC_INC);

  assign w_req_active = (r_state == REQ);
  // An ack is only useful when it answers a request for the current PC:
  // not the stale one being drained, and not one a redirect just killed.
  assign w_ack_live   = w_req_active && imem_ack && !r_drop && !w_redirect;
  assign w_slot_free  = !r_if_valid || if_ready;
  assign w_accept     = r_if_valid && if_ready;
  assign w_load_if    = w_ack_live && w_slot_free;
  assign w_load_skid  = w_ack_live && !w_slot_free;
  assign w_pop_skid   = w_accept && w_skid_full && !w_redirect;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (!w_skid_full && !w_redirect) w_next_state = REQ;
      // Without an ack the request stays open, even across a redirect
      // (the stale answer still has to be drained).
      REQ: begin
        if (imem_ack) begin
          if (w_redirect || r_drop || w_load_skid) w_next_state = IDLE;
          else w_next_state = REQ;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_drop       <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_misalign <= w_redirect && (w_raw_target[1:0] != 2'b00);
      if (w_redirect) r_pc <= w_target;
      else if (w_ack_live) r_pc <= w_pc_plus4;
      // Keep presenting the old address while its answer is outstanding.
      if (w_redirect && w_req_active && !imem_ack) begin
        r_drop <= 1'b1;
        if (!r_drop) r_stale_addr <= r_pc;
      end else if (w_req_active && imem_ack) begin
        r_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
    end else if (w_pop_skid) begin
      r_if_valid <= 1'b1;
      r_if_instr <= w_skid_instr;
      r_if_pc    <= w_skid_pc;
      r_if_pc4   <= w_skid_pc4;
    end else if (w_load_if) begin
      r_if_valid <= 1'b1;
      r_if_instr <= imem_rdata;
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc_plus4;
    end else if (w_accept) begin
      r_if_valid <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_redirect),
    .i_load (w_load_skid),
    .i_instr(imem_rdata),
    .i_pc   (r_pc),
    .i_pc4  (w_pc_plus4),
    .i_pop  (w_pop_skid),
    .o_full (w_skid_full),
    .o_instr(w_skid_instr),
    .o_pc   (w_skid_pc),
    .o_pc4  (w_skid_pc4)
  );

  assign imem_req  = w_req_active;
  assign imem_addr = r_drop ? r_stale_addr : r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_valid ? r_if_instr : NOP_INSTR;
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc4;
  assign misalign  = r_misalign;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. The memory model answers every request
// with addr ^ A5A5_A5A5 after a selectable number of wait cycles. Expected
// fetch addresses are queued as scenarios are driven; a monitor pops one per
// decode transfer and checks pc, pc4 and instruction.
module tb_pc_fetch_unit;

  localparam logic [31:0] XK = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_pc4;
  logic [31:0] br_off;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        misalign;
  logic        dbg_state;

  logic        ack_en;
  logic [1:0]  lat;
  logic [1:0]  wcnt;

  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_err;

  pc_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .br_taken  (br_taken),
    .br_pc4    (br_pc4),
    .br_off    (br_off),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_pc4    (if_pc4),
    .misalign  (misalign),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: ack after `lat` wait cycles of an open request
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 2'd0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 2'd1;
    else wcnt <= 2'd0;
  end
  assign imem_ack   = ack_en && imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr ^ XK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: one check per decode transfer
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got pc %h expected none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", if_pc, e);
          chk("out_pc4", if_pc4, e + 32'd4);
          chk("out_instr", if_instr, e ^ XK);
        end
      end
    end
  end

  // driver
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; br_taken = 1'b0; br_pc4 = '0; br_off = '0;
    jmp = 1'b0; jmp_target = '0; if_ready = 1'b1;
    ack_en = 1'b1; lat = 2'd0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);

    // sequential stream, then a 3-cycle stall at pc 8
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    exp_q.push_back(32'h30);
    rst = 1'b0;                                            // cycle 0
    tick(); chk("c1_valid", {31'b0, if_valid}, 32'd0);     // cycle 1
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    tick(); chk("c2_valid", {31'b0, if_valid}, 32'd1);     // cycle 2
    chk("c2_pc", if_pc, 32'h0);
    tick();                                                // cycle 3
    tick(); chk("c4_pc", if_pc, 32'h8);                    // cycle 4
    if_ready = 1'b0;
    for (int c = 5; c <= 6; c++) begin
      tick();
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, 32'h8 ^ XK);
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    tick(); if_ready = 1'b1;                               // cycle 7
    chk("c7_pc", if_pc, 32'h8);
    tick(); chk("c8_pc", if_pc, 32'hC);                    // cycle 8
    chk("c8_valid", {31'b0, if_valid}, 32'd1);

    // taken branch: 0x10 + 0x20 = 0x30, in-flight fetch of 0x10 discarded
    tick();                                                // cycle 9
    chk("c9_req", {31'b0, imem_req}, 32'd1);
    br_taken = 1'b1; br_pc4 = 32'h10; br_off = 32'h20;
    tick(); br_taken = 1'b0;                               // cycle 10
    chk("br_valid", {31'b0, if_valid}, 32'd0);
    chk("br_idle", {31'b0, imem_req}, 32'd0);
    tick(); chk("br_addr", imem_addr, 32'h30);             // cycle 11
    tick(); chk("br_pc", if_pc, 32'h30);                   // cycle 12

    // jmp and br_taken together while stalled: jmp wins
    tick();                                                // cycle 13
    if_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h100; br_taken = 1'b1;
    exp_q.push_back(32'h100);
    tick(); jmp = 1'b0; br_taken = 1'b0; if_ready = 1'b1;  // cycle 14
    chk("jmp_valid", {31'b0, if_valid}, 32'd0);
    tick(); chk("jmp_addr", imem_addr, 32'h100);           // cycle 15
    tick(); chk("jmp_pc", if_pc, 32'h100);                 // cycle 16
    lat = 2'd1;

    // two-cycle memory, redirect while a request is outstanding
    tick(); chk("lat_valid", {31'b0, if_valid}, 32'd0);    // cycle 17
    tick(); chk("lat_pc", if_pc, 32'h104);                 // cycle 18
    if_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h200;
    exp_q.push_back(32'h200);
    tick(); jmp = 1'b0;                                    // cycle 19
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h108);
    chk("drop_valid", {31'b0, if_valid}, 32'd0);
    tick(); if_ready = 1'b1;                               // cycle 20
    chk("drop_stale_valid", {31'b0, if_valid}, 32'd0);
    chk("drop_idle", {31'b0, imem_req}, 32'd0);
    tick(); chk("drop_new_addr", imem_addr, 32'h200);      // cycle 21
    chk("drop_new_req", {31'b0, imem_req}, 32'd1);
    tick(); chk("drop_wait_valid", {31'b0, if_valid}, 32'd0); // cycle 22
    tick(); chk("drop_pc", if_pc, 32'h200);                // cycle 23
    lat = 2'd0;

    // unaligned jump near the top of the address space, then wrap
    tick(); chk("pre_mis_pc", if_pc, 32'h204);             // cycle 24
    if_ready = 1'b0; jmp = 1'b1; jmp_target = 32'hFFFF_FFFE;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick(); jmp = 1'b0; if_ready = 1'b1;                   // cycle 25
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_valid", {31'b0, if_valid}, 32'd0);
    tick(); chk("mis_clear", {31'b0, misalign}, 32'd0);    // cycle 26
    chk("mis_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); chk("wrap_pc", if_pc, 32'hFFFF_FFFC);          // cycle 27
    chk("wrap_pc4", if_pc4, 32'h0);
    tick(); chk("wrap_next_pc", if_pc, 32'h0);             // cycle 28
    ack_en = 1'b0; jmp = 1'b1; jmp_target = 32'h41;

    // asynchronous reset during an open request with misalign high
    tick(); jmp = 1'b0;                                    // cycle 29
    chk("pre_rst_mis", {31'b0, misalign}, 32'd1);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h4);
    #2 rst = 1'b1;
    ack_en = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_mis", {31'b0, misalign}, 32'd0);
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    tick(); tick();
    exp_q.push_back(32'h0);
    rst = 1'b0;
    tick(); chk("rr_valid", {31'b0, if_valid}, 32'd0);
    tick(); chk("rr_pc", if_pc, 32'h0);
    chk("rr_valid2", {31'b0, if_valid}, 32'd1);
    tick(); if_ready = 1'b0;
    tick(); tick(); tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
